// File: rtl/sm83_bus_pkg.sv
// Shared address map constants and region decode for the SM83 bus responder.
package sm83_bus_pkg;

  localparam logic [15:0] ADDR_WRAM_BASE = 16'hC000;
  localparam logic [15:0] ADDR_SB        = 16'hFF01;
  localparam logic [15:0] ADDR_SC        = 16'hFF02;
  localparam logic [7:0]  OPEN_BUS       = 8'hFF;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_WRAM,
    REG_SB,
    REG_SC,
    REG_NONE
  } region_e;

  // ROM and WRAM window sizes follow the responder's width parameters.
  function automatic region_e decode(input logic [15:0] a, input int rom_aw, input int ram_aw);
    logic [31:0] a32;
    logic [31:0] wram_lo;
    a32     = {16'd0, a};
    wram_lo = {16'd0, ADDR_WRAM_BASE};
    if (a32 < (32'd1 << rom_aw))                                  return REG_ROM;
    else if (a32 >= wram_lo && a32 < wram_lo + (32'd1 << ram_aw)) return REG_WRAM;
    else if (a == ADDR_SB)                                        return REG_SB;
    else if (a == ADDR_SC)                                        return REG_SC;
    else                                                          return REG_NONE;
  endfunction

endpackage

// File: rtl/sm83_byte_fifo.sv
// Byte FIFO carrying serial-port output to the bench; drops on full with a sticky overflow flag.
module sm83_byte_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       ovf_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q;
  logic               pop_ok, push_ok;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign head_o  = mem_q[rp_q];
  assign ovf_o   = ovf_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands when popping.
  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Storage is not reset; only pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wp_q] <= push_data_i;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok)  rp_q <= rp_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_i & full_o & ~pop_ok) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sm83_bus_responder.sv
// ROM / WRAM / serial-stub responder on the SM83 external bus, with a byte stream out for test reporting.
module sm83_bus_responder
  import sm83_bus_pkg::*;
#(
  parameter int ROM_AW      = 9,
  parameter int RAM_AW      = 8,
  parameter int FIFO_AW     = 3,
  parameter int XFER_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              MREQ,
  input  logic              RD,
  input  logic              WR,
  input  logic [15:0]       A,
  input  logic [7:0]        D_IN,
  output logic [7:0]        D_OUT,
  output logic              D_OE,
  input  logic              LOAD_EN,
  input  logic [ROM_AW-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA,
  output logic              SER_VALID,
  output logic [7:0]        SER_DATA,
  input  logic              SER_READY,
  output logic              SER_OVF
);

  localparam int CW = $clog2(XFER_CYCLES + 1);

  logic [7:0]    rom_q [1 << ROM_AW];
  logic [7:0]    ram_q [1 << RAM_AW];

  logic          d_oe_q, wr_q;
  logic [7:0]    d_out_q, sb_q;
  logic          sc7_q, sc0_q, sc7_d, sc0_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          fifo_full;

  region_e       region;
  logic          rd_req, commit;
  logic [7:0]    rd_data;

  assign region = decode(A, ROM_AW, RAM_AW);
  assign rd_req = MREQ & RD & ~WR;
  // Only the rising edge of a write strobe commits, so a held WR writes once.
  assign commit = MREQ & WR & ~wr_q;

  assign D_OUT = d_out_q;
  assign D_OE  = d_oe_q;

  // Read mux; SC unused bits float high.
  always_comb begin
    rd_data = OPEN_BUS;
    case (region)
      REG_ROM:  rd_data = rom_q[A[ROM_AW-1:0]];
      REG_WRAM: rd_data = ram_q[A[RAM_AW-1:0]];
      REG_SB:   rd_data = sb_q;
      REG_SC:   rd_data = {sc7_q, 6'b111111, sc0_q};
      default:  rd_data = OPEN_BUS;
    endcase
  end

  // Backdoor ROM load; the registered read above sees the old byte on a same-cycle collision.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) rom_q[LOAD_ADDR] <= LOAD_DATA;
  end

  // WRAM write port.
  always_ff @(posedge CLK) begin
    if (commit && region == REG_WRAM) ram_q[A[RAM_AW-1:0]] <= D_IN;
  end

  // Serial control: countdown by default, SC writes start or abort a transfer; busy starts are dropped.
  always_comb begin
    sc7_d = sc7_q;
    sc0_d = sc0_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) sc7_d = 1'b0;
    end
    if (commit && region == REG_SC) begin
      if (D_IN[7] && !sc7_q) begin
        sc7_d = 1'b1;
        sc0_d = D_IN[0];
        cnt_d = CW'(XFER_CYCLES);
        push  = 1'b1;
      end else if (!D_IN[7]) begin
        sc7_d = 1'b0;
        sc0_d = D_IN[0];
        cnt_d = '0;
      end
    end
  end

  // Bus-facing registers and serial state.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      d_oe_q  <= 1'b0;
      d_out_q <= 8'h00;
      wr_q    <= 1'b0;
      sb_q    <= 8'h00;
      sc7_q   <= 1'b0;
      sc0_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      d_oe_q <= rd_req;
      if (rd_req) d_out_q <= rd_data;
      wr_q <= MREQ & WR;
      if (commit && region == REG_SB) sb_q <= D_IN;
      sc7_q <= sc7_d;
      sc0_q <= sc0_d;
      cnt_q <= cnt_d;
    end
  end

  sm83_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .push_i      (push),
    .push_data_i (sb_q),
    .pop_i       (SER_READY),
    .valid_o     (SER_VALID),
    .head_o      (SER_DATA),
    .full_o      (fifo_full),
    .ovf_o       (SER_OVF)
  );

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Scoreboard bench: stimulus queues expected read/serial bytes, a negedge monitor pops and compares.
module tb_sm83_bus_responder;

  localparam int XFER = 8;

  logic        CLK = 1'b0, nRESET = 1'b0;
  logic        MREQ = 1'b0, RD = 1'b0, WR = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  D_IN = 8'h00;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        LOAD_EN = 1'b0;
  logic [8:0]  LOAD_ADDR = 9'h000;
  logic [7:0]  LOAD_DATA = 8'h00;
  logic        SER_VALID, SER_READY = 1'b0, SER_OVF;
  logic [7:0]  SER_DATA;

  int checks = 0, failures = 0;
  logic [7:0] rd_exp[$];
  logic [7:0] ser_exp[$];

  sm83_bus_responder #(.ROM_AW(9), .RAM_AW(8), .FIFO_AW(3), .XFER_CYCLES(XFER)) dut (
    .CLK(CLK), .nRESET(nRESET), .MREQ(MREQ), .RD(RD), .WR(WR), .A(A), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OE(D_OE), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .SER_VALID(SER_VALID), .SER_DATA(SER_DATA), .SER_READY(SER_READY), .SER_OVF(SER_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented read response and every accepted serial byte is matched against the queues.
  always @(negedge CLK) begin
    if (D_OE) begin
      if (rd_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=%0h expected=none", D_OUT);
      end else chk("rd_data", D_OUT, rd_exp.pop_front());
    end
    if (SER_VALID && SER_READY) begin
      if (ser_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL ser_unexpected actual=%0h expected=none", SER_DATA);
      end else chk("ser_data", SER_DATA, ser_exp.pop_front());
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    MREQ = 1'b1; WR = 1'b1; A = a; D_IN = d;
    cyc();
    MREQ = 1'b0; WR = 1'b0;
    cyc();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
    MREQ = 1'b1; RD = 1'b1; A = a;
    rd_exp.push_back(exp);
    cyc();
    MREQ = 1'b0; RD = 1'b0;
  endtask

  // Full transfer: load SB, start, wait out the busy window.
  task automatic xfer(input logic [7:0] sb, input bit expect_push);
    bus_write(16'hFF01, sb);
    if (expect_push) ser_exp.push_back(sb);
    bus_write(16'hFF02, 8'h81);
    repeat (XFER + 2) cyc();
  endtask

  task automatic drain(input string name, input int exp_n);
    int n;
    n = 0;
    SER_READY = 1'b1;
    for (int i = 0; i < 40 && SER_VALID; i++) begin
      n++;
      cyc();
    end
    SER_READY = 1'b0;
    chk(name, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preload ROM under reset.
    LOAD_EN = 1'b1;
    LOAD_ADDR = 9'h005; LOAD_DATA = 8'hA5; cyc();
    LOAD_ADDR = 9'h1FF; LOAD_DATA = 8'h5A; cyc();
    LOAD_EN = 1'b0;
    chk("rst_d_oe", D_OE, 0);
    chk("rst_d_out", D_OUT, 0);
    chk("rst_ser_valid", SER_VALID, 0);
    chk("rst_ser_ovf", SER_OVF, 0);
    nRESET = 1'b1;
    cyc();

    // Decode boundaries.
    bus_read(16'h0005, 8'hA5);
    bus_read(16'h8000, 8'hFF);
    bus_read(16'h01FF, 8'h5A);
    bus_read(16'h0200, 8'hFF);
    bus_read(16'hFF00, 8'hFF);
    cyc();

    // Held write commits once with the first-cycle data.
    MREQ = 1'b1; WR = 1'b1; A = 16'hC010; D_IN = 8'h3C;
    cyc();
    D_IN = 8'h99;
    cyc(); cyc();
    MREQ = 1'b0; WR = 1'b0;
    cyc();
    bus_read(16'hC010, 8'h3C);
    bus_write(16'hC0FF, 8'h77);
    bus_write(16'hC100, 8'h12);
    bus_read(16'hC0FF, 8'h77);
    bus_read(16'hC100, 8'hFF);
    bus_write(16'h0005, 8'h11);
    bus_read(16'h0005, 8'hA5);
    cyc();

    // Basic transfer and SC busy window.
    SER_READY = 1'b0;
    bus_write(16'hFF01, 8'h50);
    ser_exp.push_back(8'h50);
    bus_write(16'hFF02, 8'h81);
    chk("ser_valid_after_start", SER_VALID, 1);
    chk("ser_head_after_start", SER_DATA, 8'h50);
    for (int k = 2; k <= XFER + 2; k++) bus_read(16'hFF02, (k <= XFER) ? 8'hFF : 8'h7F);
    drain("drain_one", 1);

    // Busy start ignored, abort clears SC[7].
    SER_READY = 1'b1;
    bus_write(16'hFF01, 8'h51);
    ser_exp.push_back(8'h51);
    bus_write(16'hFF02, 8'h81);
    bus_write(16'hFF01, 8'h52);
    bus_write(16'hFF02, 8'h81);
    bus_write(16'hFF02, 8'h01);
    bus_read(16'hFF02, 8'h7F);
    repeat (12) cyc();
    chk("busy_no_push", SER_VALID, 0);
    ser_exp.push_back(8'h52);
    bus_write(16'hFF02, 8'h81);
    repeat (12) cyc();
    chk("restart_after_abort", ser_exp.size(), 0);
    SER_READY = 1'b0;

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 8; i++) xfer(8'(8'h70 + i), 1'b1);
    chk("full_valid", SER_VALID, 1);
    bus_write(16'hFF01, 8'h78);
    ser_exp.push_back(8'h78);
    MREQ = 1'b1; WR = 1'b1; A = 16'hFF02; D_IN = 8'h81; SER_READY = 1'b1;
    cyc();
    MREQ = 1'b0; WR = 1'b0; SER_READY = 1'b0;
    repeat (XFER + 2) cyc();
    chk("pushpop_no_ovf", SER_OVF, 0);
    drain("pushpop_count", 8);

    // Overflow: ninth byte dropped.
    for (int i = 0; i < 8; i++) xfer(8'(8'h60 + i), 1'b1);
    chk("ovf_before", SER_OVF, 0);
    xfer(8'h68, 1'b0);
    chk("ovf_after", SER_OVF, 1);
    drain("ovf_count", 8);
    chk("ser_empty_after_drain", SER_VALID, 0);

    // Asynchronous reset mid-transfer, with a read response on the bus.
    bus_write(16'hFF01, 8'hAA);
    bus_write(16'hFF02, 8'h81);
    MREQ = 1'b1; RD = 1'b1; A = 16'h0005;
    @(posedge CLK); #2;
    chk("pre_rst_d_oe", D_OE, 1);
    chk("pre_rst_ser_valid", SER_VALID, 1);
    nRESET = 1'b0;
    #1;
    chk("arst_d_oe", D_OE, 0);
    chk("arst_d_out", D_OUT, 0);
    chk("arst_ser_valid", SER_VALID, 0);
    chk("arst_ser_ovf", SER_OVF, 0);
    MREQ = 1'b0; RD = 1'b0;
    cyc();
    nRESET = 1'b1;
    cyc();
    bus_read(16'hFF02, 8'h7E);
    bus_read(16'hFF01, 8'h00);
    bus_read(16'h0005, 8'hA5);
    repeat (4) cyc();
    chk("rd_queue_empty", rd_exp.size(), 0);
    chk("ser_queue_empty", ser_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
